// File: rtl/tiny_cpu_core.sv
// Single-cycle 4-register accumulator-style core with host-loadable 16x8 imem,
// 16xDATA_W dmem, start/halt control, memory-mapped output and retire counter.
module tiny_cpu_core #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_we,
  input  logic              load_sel,
  input  logic [3:0]        load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              running,
  output logic              halted,
  output logic [3:0]        pc,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] regs [4];
  logic [7:0]        imem [16];
  logic [DATA_W-1:0] dmem [16];
  logic [7:0]        instr;
  logic [7:0]        imem_wdata;
  logic [1:0]        op;
  logic [1:0]        ra;
  logic [1:0]        rb;
  logic [1:0]        func;
  logic [3:0]        imm;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W-1:0] alu_res;
  logic              is_halt;
  logic              begin_run;

  assign instr     = imem[pc];
  assign op        = instr[7:6];
  assign ra        = instr[5:4];
  assign rb        = instr[3:2];
  assign func      = instr[1:0];
  assign imm       = instr[3:0];
  assign a_val     = regs[ra];
  assign b_val     = regs[rb];
  assign is_halt   = (instr == 8'hFF);
  assign begin_run = start && (state != RUN);

  // Narrow data paths zero-extend into the 8-bit instruction word.
  generate
    if (DATA_W >= 8) begin : g_wide
      assign imem_wdata = load_data[7:0];
    end else begin : g_narrow
      assign imem_wdata = {{(8-DATA_W){1'b0}}, load_data};
    end
  endgenerate

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)   state_next = RUN;    else state_next = IDLE;
      RUN:     if (is_halt) state_next = HALTED; else state_next = RUN;
      HALTED:  if (start)   state_next = RUN;    else state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    running = 1'b0;
    halted  = 1'b0;
    case (state)
      RUN:     running = 1'b1;
      HALTED:  halted  = 1'b1;
      default: begin
        running = 1'b0;
        halted  = 1'b0;
      end
    endcase
  end

  // ALU, truncated to DATA_W.
  always_comb begin
    alu_res = a_val;
    case (func)
      2'b00:   alu_res = a_val + b_val;
      2'b01:   alu_res = a_val - b_val;
      2'b10:   alu_res = a_val & b_val;
      2'b11:   alu_res = a_val ^ b_val;
      default: alu_res = a_val;
    endcase
  end

  // Datapath: execution in RUN, host loads only while not running and not starting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= 4'd0;
      retired   <= {CNT_W{1'b0}};
      out_data  <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
      for (int i = 0; i < 4; i++)  regs[i] <= {DATA_W{1'b0}};
      for (int i = 0; i < 16; i++) imem[i] <= 8'h00;
      for (int i = 0; i < 16; i++) dmem[i] <= {DATA_W{1'b0}};
    end else begin
      out_valid <= 1'b0;
      if (begin_run) begin
        pc      <= 4'd0;
        retired <= {CNT_W{1'b0}};
      end else if (state == RUN) begin
        if (!is_halt) begin
          retired <= (&retired) ? retired : retired + CNT_ONE;
          pc      <= pc + 4'd1;
          case (op)
            2'b00: regs[ra] <= dmem[imm];
            2'b01: begin
              dmem[imm] <= a_val;
              if (imm == 4'hF) begin
                out_data  <= a_val;
                out_valid <= 1'b1;
              end
            end
            2'b10: regs[ra] <= alu_res;
            2'b11: if (a_val == {DATA_W{1'b0}}) pc <= imm;
            default: pc <= pc + 4'd1;
          endcase
        end
      end else if (load_we) begin
        if (load_sel) dmem[load_addr] <= load_data;
        else          imem[load_addr] <= imem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_tiny_cpu_core.sv
// Directed bench for tiny_cpu_core: 8-bit instance fully checked, a 12-bit
// instance shares the stimulus to check width-dependent arithmetic.
module tb_tiny_cpu_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        load_we = 1'b0;
  logic        load_sel = 1'b0;
  logic [3:0]  load_addr = 4'd0;
  logic [7:0]  load_data = 8'd0;
  logic [11:0] load_data_w;
  logic [7:0]  out_data;
  logic        out_valid, running, halted;
  logic [3:0]  pc;
  logic [15:0] retired;
  logic [11:0] out_data_w;
  logic        out_valid_w, running_w, halted_w;
  logic [3:0]  pc_w;
  logic [15:0] retired_w;
  int total = 0;
  int bad = 0;

  assign load_data_w = {4'h0, load_data};

  always #5 clk = ~clk;

  tiny_cpu_core #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_we(load_we),
    .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .out_data(out_data), .out_valid(out_valid), .running(running),
    .halted(halted), .pc(pc), .retired(retired)
  );

  tiny_cpu_core #(.DATA_W(12), .CNT_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .load_we(load_we),
    .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data_w),
    .out_data(out_data_w), .out_valid(out_valid_w), .running(running_w),
    .halted(halted_w), .pc(pc_w), .retired(retired_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    load_sel = sel; load_addr = addr; load_data = data; load_we = 1'b1;
    tick();
    load_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_prog(input logic [7:0] p0, p1, p2, p3, p4);
    load(1'b0, 4'd0, p0); load(1'b0, 4'd1, p1); load(1'b0, 4'd2, p2);
    load(1'b0, 4'd3, p3); load(1'b0, 4'd4, p4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_v;
    #2;
    check("rst_pc", pc, 0); check("rst_ret", retired, 0); check("rst_out", out_data, 0);
    check("rst_valid", out_valid, 0); check("rst_run", running, 0); check("rst_halt", halted, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic program: 5 + 7 stored to address 15.
    load_prog(8'h00, 8'h11, 8'h84, 8'h4F, 8'hFF);
    load(1'b1, 4'd0, 8'd5); load(1'b1, 4'd1, 8'd7);
    check("idle_run", running, 0);
    do_start();
    check("b_run", running, 1); check("b_pc0", pc, 0); check("b_ret0", retired, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("b_novalid", out_valid, 0);
    end
    tick();
    check("b_valid", out_valid, 1); check("b_out", out_data, 12); check("b_out_w", out_data_w, 12);
    tick();
    check("b_valid_off", out_valid, 0); check("b_halt", halted, 1); check("b_run_off", running, 0);
    check("b_ret", retired, 4); check("b_pc", pc, 4);

    // Wrap arithmetic: 3 - 5.
    load(1'b1, 4'd0, 8'd3); load(1'b1, 4'd1, 8'd5);
    load_prog(8'h00, 8'h11, 8'h85, 8'h4F, 8'hFF);
    do_start();
    for (int i = 1; i <= 4; i++) tick();
    check("w_valid", out_valid, 1); check("w_out8", out_data, 8'hFE); check("w_out12", out_data_w, 12'hFFE);
    tick();
    check("w_halt", halted, 1);

    // Loop and branch: countdown 2,1,0 then halt.
    load(1'b1, 4'd0, 8'd3); load(1'b1, 4'd1, 8'd1);
    load_prog(8'h00, 8'h11, 8'h85, 8'h4F, 8'hC6);
    load(1'b0, 4'd5, 8'hE2); load(1'b0, 4'd6, 8'hFF);
    do_start();
    for (int i = 1; i <= 14; i++) begin
      tick();
      exp_v = ((i % 4) == 0);
      check("l_valid", out_valid, exp_v);
      if (exp_v) check("l_out", out_data, 3 - i / 4);
      if (i < 14) check("l_running", running, 1);
    end
    check("l_halt", halted, 1); check("l_ret", retired, 13); check("l_pc", pc, 6);

    // Load gating: write during RUN is ignored.
    load(1'b1, 4'd0, 8'd5); load(1'b1, 4'd1, 8'd7);
    load_prog(8'h00, 8'h11, 8'h84, 8'h4F, 8'hFF);
    do_start();
    tick();
    load(1'b0, 4'd0, 8'hFF);
    tick(); tick();
    check("g_valid", out_valid, 1); check("g_out", out_data, 12);
    tick();
    check("g_halt", halted, 1); check("g_ret", retired, 4);
    load(1'b0, 4'd0, 8'hFF);
    do_start();
    check("g_run", running, 1);
    tick();
    check("g_halt2", halted, 1); check("g_ret2", retired, 0); check("g_pc2", pc, 0);
    // start and load_we together: write dropped, imem[0] stays HALT.
    load_sel = 1'b0; load_addr = 4'd0; load_data = 8'h00; load_we = 1'b1; start = 1'b1;
    tick();
    load_we = 1'b0; start = 1'b0;
    check("g_both_run", running, 1);
    tick();
    check("g_both_halt", halted, 1); check("g_both_ret", retired, 0);

    // PC wrap with no HALT.
    for (int i = 0; i < 16; i++) load(1'b0, i[3:0], 8'h84);
    do_start();
    for (int i = 1; i <= 15; i++) tick();
    check("p_pc15", pc, 15);
    tick();
    check("p_pc0", pc, 0); check("p_ret16", retired, 16); check("p_run", running, 1);
    tick(); tick(); tick();
    check("p_pc3", pc, 3); check("p_ret19", retired, 19);

    // Asynchronous reset mid-run.
    #3 rst_n = 1'b0;
    #1;
    check("r_run", running, 0); check("r_pc", pc, 0); check("r_ret", retired, 0);
    check("r_out", out_data, 0); check("r_halt", halted, 0); check("r_valid", out_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    do_start();
    for (int i = 1; i <= 20; i++) tick();
    check("r2_halt", halted, 0); check("r2_run", running, 1);
    check("r2_ret", retired, 20); check("r2_pc", pc, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
